stack_exec_unit: RTL and testbench

Data-stack execution unit for the stack-based processor: holds the LIFO data stack, executes stack and arithmetic opcodes, and drives the signed top-of-stack value. The processor testbench observes that value as `top`. The processor's decode stage issues one opcode per valid/ready handshake. This block owns all stack state, overflow/underflow detection and the two-cycle multiply path.

---
 rtl/stack_exec_unit.sv | 149 ++++++++++++++
 tb/tb_stack_exec_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_exec_unit.sv
// Data-stack execution unit: LIFO stack with a registered top entry, single-cycle
// stack/arithmetic opcodes, a two-cycle multiply and sticky error reporting.
module stack_exec_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         operand,
  output logic signed [WIDTH-1:0]  top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO       = (AW+1)'(2);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0, OP_PUSH = 4'd1, OP_POP = 4'd2, OP_DUP = 4'd3, OP_SWAP = 4'd4,
    OP_ADD  = 4'd5, OP_SUB  = 4'd6, OP_MUL = 4'd7, OP_NEG = 4'd8
  } op_t;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t           state, state_nx;
  logic             phase;
  op_t              opc;
  logic             accept, underflow, overflow, illegal, op_err;
  logic [1:0]       code;
  logic [WIDTH-1:0] mem [DEPTH-1];
  logic [WIDTH-1:0] second, prod;
  logic [AW-1:0]    t_idx, s_idx;

  // Entries below T live at mem[0 .. depth-2]; t_idx is where T spills on a push.
  assign t_idx  = AW'(depth - 1'b1);
  assign s_idx  = AW'(depth - TWO);
  assign second = mem[s_idx];

  assign opc      = op_t'(op);
  assign op_ready = (state == IDLE);
  assign accept   = op_valid && op_ready;
  assign empty    = (depth == '0);
  assign full     = (depth == DEPTH_MAX);

  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    illegal   = 1'b0;
    case (opc)
      OP_NOP:                         ;
      OP_PUSH:                        overflow  = full;
      OP_POP, OP_NEG:                 underflow = empty;
      OP_DUP: begin
        underflow = empty;
        overflow  = full;
      end
      OP_SWAP, OP_ADD, OP_SUB, OP_MUL: underflow = (depth < TWO);
      default:                        illegal   = 1'b1;
    endcase
    op_err = underflow || overflow || illegal;
    code   = underflow ? 2'd1 : overflow ? 2'd2 : illegal ? 2'd3 : 2'd0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && opc == OP_MUL && !op_err) state_nx = MUL_BUSY;
      MUL_BUSY: if (phase) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= (state == MUL_BUSY) ? ~phase : 1'b0;
    end
  end

  // Array contents need no reset: depth alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (accept && !op_err) begin
      case (opc)
        OP_PUSH, OP_DUP: if (!empty) mem[t_idx] <= top;
        OP_SWAP:         mem[s_idx] <= top;
        default:         ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      top      <= '0;
      depth    <= '0;
      err      <= 1'b0;
      err_code <= '0;
      prod     <= '0;
    end else if (state == MUL_BUSY) begin
      // First busy cycle forms the product, second commits it.
      if (!phase) begin
        prod <= second * top;
      end else begin
        top   <= prod;
        depth <= depth - 1'b1;
      end
    end else if (accept) begin
      if (op_err) begin
        if (!err) begin
          err      <= 1'b1;
          err_code <= code;
        end
      end else begin
        case (opc)
          OP_PUSH: begin
            top   <= operand;
            depth <= depth + 1'b1;
          end
          OP_DUP:  depth <= depth + 1'b1;
          OP_POP: begin
            top   <= (depth > (AW+1)'(1)) ? second : '0;
            depth <= depth - 1'b1;
          end
          OP_SWAP: top <= second;
          OP_ADD: begin
            top   <= second + top;
            depth <= depth - 1'b1;
          end
          OP_SUB: begin
            top   <= second - top;
            depth <= depth - 1'b1;
          end
          OP_NEG:  top <= -top;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_exec_unit.sv
// Bench for stack_exec_unit: directed scenarios plus random opcode streams,
// all checked against a queue-based stack model.
module tb_stack_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op = '0;
  logic [31:0] operand = '0;
  logic [31:0] top;
  logic [4:0]  depth;
  logic        empty, full, err;
  logic [1:0]  err_code;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] stk[$];
  logic        m_err;
  logic [1:0]  m_code;

  stack_exec_unit #(.WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .operand(operand), .top(top), .depth(depth), .empty(empty),
    .full(full), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (stk.size() > 0) ? stk[stk.size()-1] : 32'd0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".top"},   top, m_top());
    check({tag, ".depth"}, depth, stk.size());
    check({tag, ".empty"}, empty, stk.size() == 0);
    check({tag, ".full"},  full, stk.size() == 16);
    check({tag, ".err"},   err, m_err);
    check({tag, ".code"},  err_code, m_code);
    check({tag, ".ready"}, op_ready, 1'b1);
  endtask

  // Reference semantics straight from the opcode table.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] v, output bit mul_ok);
    int n;
    logic [1:0] e;
    logic [31:0] a, b;
    n = stk.size();
    e = 2'd0;
    case (o)
      4'd0: ;
      4'd1: if (n == 16) e = 2'd2; else stk.push_back(v);
      4'd2: if (n == 0) e = 2'd1; else void'(stk.pop_back());
      4'd3: if (n == 0) e = 2'd1; else if (n == 16) e = 2'd2; else stk.push_back(stk[n-1]);
      4'd4, 4'd5, 4'd6, 4'd7:
        if (n < 2) e = 2'd1;
        else begin
          a = stk.pop_back();
          b = stk.pop_back();
          case (o)
            4'd4: begin stk.push_back(a); stk.push_back(b); end
            4'd5: stk.push_back(b + a);
            4'd6: stk.push_back(b - a);
            default: stk.push_back(b * a);
          endcase
        end
      4'd8: if (n == 0) e = 2'd1; else stk[n-1] = -stk[n-1];
      default: e = 2'd3;
    endcase
    if (e != 0 && !m_err) begin
      m_err  = 1'b1;
      m_code = e;
    end
    mul_ok = (o == 4'd7) && (e == 0);
  endtask

  // Called one time unit after an edge; issues one opcode and waits out any multiply.
  task automatic do_op(input logic [3:0] o, input logic [31:0] v);
    bit mul_ok;
    logic [31:0] old_top;
    int old_depth;
    old_top   = m_top();
    old_depth = stk.size();
    op_valid = 1'b1; op = o; operand = v;
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_apply(o, v, mul_ok);
    if (mul_ok) begin
      for (int c = 0; c < 2; c++) begin
        check("mulbusy.ready", op_ready, 1'b0);
        check("mulbusy.top", top, old_top);
        check("mulbusy.depth", depth, old_depth);
        @(posedge clk); #1;
      end
    end
    check_all("op");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    stk.delete();
    m_err = 1'b0;
    m_code = 2'd0;
    check_all("reset");
  endtask

  logic [31:0] seq_exp [6];
  logic [3:0]  seq_op  [6];
  logic [31:0] seq_val [6];

  initial begin
    logic [3:0]  ro;
    logic [31:0] rv;
    int unsigned r;

    do_reset();

    // Push/arithmetic sequence
    seq_op  = '{4'd1, 4'd1, 4'd5, 4'd3, 4'd8, 4'd6};
    seq_val = '{32'd7, -32'sd3, 32'd0, 32'd0, 32'd0, 32'd0};
    seq_exp = '{32'd7, 32'hFFFFFFFD, 32'd4, 32'd4, 32'hFFFFFFFC, 32'd8};
    for (int i = 0; i < 6; i++) begin
      do_op(seq_op[i], seq_val[i]);
      check("seq.top", top, seq_exp[i]);
    end
    check("seq.depth", depth, 5'd1);

    // MUL with a PUSH queued behind it, op_valid held high throughout
    do_reset();
    do_op(4'd1, 32'd6);
    do_op(4'd1, -32'sd5);
    op_valid = 1'b1; op = 4'd7;
    @(posedge clk); #1;
    op = 4'd1; operand = 32'd42;
    check("mulq.ready1", op_ready, 1'b0);
    @(posedge clk); #1;
    check("mulq.ready2", op_ready, 1'b0);
    check("mulq.top2", top, 32'hFFFFFFFB);
    @(posedge clk); #1;
    check("mulq.prod", top, 32'hFFFFFFE2);
    check("mulq.depth", depth, 5'd1);
    check("mulq.ready3", op_ready, 1'b1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("mulq.push", top, 32'd42);
    check("mulq.depth2", depth, 5'd2);
    void'(stk.pop_back()); void'(stk.pop_back());
    stk.push_back(32'hFFFFFFE2); stk.push_back(32'd42);
    check_all("mulq");

    // Wrap-around
    do_reset();
    do_op(4'd1, 32'h7FFFFFFF);
    do_op(4'd1, 32'd1);
    do_op(4'd5, 32'd0);
    check("wrap.add", top, 32'h80000000);
    check("wrap.err", err, 1'b0);
    do_op(4'd1, 32'h80000000);
    do_op(4'd8, 32'd0);
    check("wrap.neg", top, 32'h80000000);

    // Fill, overflow, drain, underflow
    do_reset();
    for (int i = 1; i <= 16; i++) do_op(4'd1, 32'(i));
    check("fill.full", full, 1'b1);
    do_op(4'd1, 32'd99);
    check("ovf.err", err, 1'b1);
    check("ovf.code", err_code, 2'd2);
    check("ovf.top", top, 32'd16);
    check("ovf.depth", depth, 5'd16);
    for (int i = 0; i < 16; i++) do_op(4'd2, 32'd0);
    check("drain.empty", empty, 1'b1);
    do_op(4'd4, 32'd0);
    check("unf.code", err_code, 2'd2);

    // Illegal opcode, erroring MUL, reset mid-multiply
    do_reset();
    do_op(4'd12, 32'd0);
    check("ill.code", err_code, 2'd3);
    do_op(4'd1, 32'd5);
    do_op(4'd7, 32'd0);
    check("ill.mulready", op_ready, 1'b1);
    check("ill.code2", err_code, 2'd3);
    check("ill.top", top, 32'd5);
    do_op(4'd1, 32'd3);
    op_valid = 1'b1; op = 4'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("rstmul.busy", op_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    stk.delete(); m_err = 1'b0; m_code = 2'd0;
    check_all("rstmul");

    // Random streams, reset between batches so error stickiness does not dominate
    for (int b = 0; b < 6; b++) begin
      do_reset();
      for (int k = 0; k < 120; k++) begin
        r = $urandom_range(0, 99);
        if      (r < 30) ro = 4'd1;
        else if (r < 42) ro = 4'd2;
        else if (r < 50) ro = 4'd3;
        else if (r < 58) ro = 4'd4;
        else if (r < 66) ro = 4'd5;
        else if (r < 74) ro = 4'd6;
        else if (r < 84) ro = 4'd7;
        else if (r < 92) ro = 4'd8;
        else if (r < 97) ro = 4'd0;
        else             ro = 4'($urandom_range(9, 15));
        case ($urandom_range(0, 3))
          0:       rv = 32'h80000000;
          1:       rv = 32'($urandom_range(0, 20)) - 32'd10;
          default: rv = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk); #1;
          check_all("idle");
        end
        do_op(ro, rv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
